// File: rtl/point_encoder_pkg.sv
// Types and constants shared by the point encoder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "p25519_defs.sv"

package point_encoder_pkg;

    localparam int FIELD_W = 255;
    localparam int ENC_W   = FIELD_W + 1;
    localparam int NBYTES  = ENC_W / 8;

    localparam logic [FIELD_W-1:0] P25519 = `P25519;

    // Encoder control states; encoding values are fixed.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        SEND   = 2'd2
    } state_t;

endpackage

// File: rtl/point_encoder_if.sv
// Point input handshake plus encoded byte stream output.
// Latency: n/a (signal bundle only).
// Backpressure: pt_valid/pt_ready upstream, out_valid/out_ready downstream.
interface point_encoder_if #(
    parameter int N = 255
);
    logic [N-1:0] px;
    logic [N-1:0] py;
    logic         pt_valid;
    logic         pt_ready;
    logic [N:0]   exp_enc;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    // Producer of points / consumer of bytes.
    modport master (
        output px, py, pt_valid, exp_enc, out_ready,
        input  pt_ready, out_data, out_valid, out_last
    );

    // The encoder itself.
    modport slave (
        input  px, py, pt_valid, exp_enc, out_ready,
        output pt_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/p25519_defs.sv
// Shared field constants for the Curve25519 datapath.
// Latency: n/a (macro definitions only).
// Backpressure: n/a.
`ifndef P25519_DEFS_SV
`define P25519_DEFS_SV
// Field prime 2^255 - 19.
`define P25519 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed
`endif

// File: rtl/point_encoder_canon_reduce.sv
// Canonical reduction mod P25519 for inputs below 2^N: one conditional subtract.
// Latency: combinational.
// Backpressure: none.
module canon_reduce
    import point_encoder_pkg::*;
#(
    parameter int N = 255
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] z
);

    localparam logic [N-1:0] P = N'(P25519);

    // Inputs in [P, 2^N-1] land in [0, 18]; everything else passes through.
    always_comb begin
        z = (a >= P) ? (a - P) : a;
    end

endmodule

// File: rtl/point_encoder.sv
// Canonicalises an affine point, builds the 256-bit compressed encoding, streams it LSB byte first.
// Latency: capture to first byte 2 cycles; at least 34 cycles per point with out_ready held high.
// Backpressure: pt_ready only in IDLE; a stalled byte holds out_data/out_last until accepted.
module point_encoder
    import point_encoder_pkg::*;
#(
    parameter int N        = 255,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    point_encoder_if.slave  bus,
    output logic            busy,
    output logic            match,
    output logic            match_valid
);

    state_t       state_q;
    state_t       state_d;
    logic [4:0]   idx;
    logic [N-1:0] px_q;
    logic [N-1:0] py_q;
    logic [N:0]   exp_q;
    logic [N:0]   enc_q;
    logic [N:0]   enc_d;
    logic [N-1:0] xr;
    logic [N-1:0] yr;
    logic         match_q;
    logic         match_valid_q;
    logic         pt_ready;
    logic         out_valid;
    logic         busy_c;
    logic         unused_xr_hi;

    canon_reduce #(.N(N)) u_reduce_x (.a(px_q), .z(xr));
    canon_reduce #(.N(N)) u_reduce_y (.a(py_q), .z(yr));

    // Only the parity of x survives into the encoding.
    assign unused_xr_hi = ^xr[N-1:1];
    assign enc_d        = {xr[0], yr};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        pt_ready  = 1'b0;
        busy_c    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                pt_ready = 1'b1;
                if (bus.pt_valid) begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                busy_c  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                busy_c    = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready && (idx == 5'd31)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Point capture, encoding register, comparator and byte index.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= 5'd0;
            px_q          <= '0;
            py_q          <= '0;
            exp_q         <= '0;
            enc_q         <= '0;
            match_q       <= 1'b0;
            match_valid_q <= 1'b0;
        end else begin
            match_valid_q <= 1'b0;
            if ((state_q == IDLE) && bus.pt_valid) begin
                px_q  <= bus.px;
                py_q  <= bus.py;
                exp_q <= bus.exp_enc;
            end
            if (state_q == REDUCE) begin
                enc_q         <= enc_d;
                idx           <= 5'd0;
                match_q       <= CHECK_EN && (enc_d == exp_q);
                match_valid_q <= CHECK_EN;
            end
            if ((state_q == SEND) && bus.out_ready) begin
                // Leaving SEND after byte 31 clears the index, so it never wraps.
                idx <= (idx == 5'd31) ? 5'd0 : idx + 5'd1;
            end
        end
    end

    assign bus.pt_ready  = pt_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_valid && (idx == 5'd31);
    assign bus.out_data  = out_valid ? enc_q[{idx, 3'b000} +: 8] : 8'h00;
    assign busy          = busy_c;
    assign match         = match_q;
    assign match_valid   = match_valid_q;

endmodule

// File: tb/tb_point_encoder.sv
// Directed bench for point_encoder: reset, reduction corners, comparator, stalls, abort, back-to-back.
// Latency: checks the 2-cycle capture-to-first-byte gap.
// Backpressure: exercises toggled out_ready and held pt_valid.
module tb_point_encoder;

    logic clk;
    logic rst;
    logic busy;
    logic match;
    logic match_valid;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [254:0] ALL1 = '1;
    localparam logic [254:0] P    = ALL1 - 255'd18;

    point_encoder_if #(.N(255)) bus ();

    point_encoder #(.N(255), .CHECK_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .match       (match),
        .match_valid (match_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a point at a negedge in IDLE; returns at the first SEND negedge.
    task automatic send_point(input logic [254:0] x, input logic [254:0] y,
                              input logic [255:0] e, input logic exp_match, input bit hold);
        bus.px       = x;
        bus.py       = y;
        bus.exp_enc  = e;
        bus.pt_valid = 1'b1;
        chk("idle_pt_ready", {255'd0, bus.pt_ready}, 256'd1);
        chk("idle_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        if (!hold) bus.pt_valid = 1'b0;
        chk("reduce_pt_ready", {255'd0, bus.pt_ready}, 256'd0);
        chk("reduce_busy", {255'd0, busy}, 256'd1);
        chk("reduce_out_valid", {255'd0, bus.out_valid}, 256'd0);
        @(negedge clk);
        chk("send_out_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("match", {255'd0, match}, {255'd0, exp_match});
    endtask

    // Consume all 32 bytes starting at the first SEND negedge; ends at the following IDLE negedge.
    task automatic stream(input logic [255:0] e, input bit toggle);
        int   i     = 0;
        int   guard = 0;
        bit   rdy   = 1'b0;
        bit   first = 1'b1;
        logic [7:0] b;
        while (i < 32 && guard < 200) begin
            b = e[8*i +: 8];
            chk($sformatf("out_valid[%0d]", i), {255'd0, bus.out_valid}, 256'd1);
            chk($sformatf("out_data[%0d]", i), {248'd0, bus.out_data}, {248'd0, b});
            chk($sformatf("out_last[%0d]", i), {255'd0, bus.out_last}, {255'd0, (i == 31)});
            chk("match_valid", {255'd0, match_valid}, {255'd0, first});
            chk("send_pt_ready", {255'd0, bus.pt_ready}, 256'd0);
            first = 1'b0;
            rdy = toggle ? ~rdy : 1'b1;
            bus.out_ready = rdy;
            if (rdy) i++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL stream_timeout observed=%0d bytes expected=32", i);
        end
        bus.out_ready = 1'b1;
        chk("end_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("end_busy", {255'd0, busy}, 256'd0);
        chk("end_pt_ready", {255'd0, bus.pt_ready}, 256'd1);
    endtask

    logic [255:0] e1;
    logic [255:0] e2a;
    logic [255:0] e2b;
    logic [255:0] e5;

    initial begin
        rst           = 1'b1;
        bus.px        = '0;
        bus.py        = '0;
        bus.exp_enc   = '0;
        bus.pt_valid  = 1'b0;
        bus.out_ready = 1'b1;
        e1  = {1'b1, 255'd2};
        e2a = {1'b1, 255'd18};
        e2b = {1'b0, 255'd18};
        e5  = {1'b0, 255'hAB << 80};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pt_ready", {255'd0, bus.pt_ready}, 256'd1);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("rst_out_last", {255'd0, bus.out_last}, 256'd0);
        chk("rst_out_data", {248'd0, bus.out_data}, 256'd0);
        chk("rst_match", {255'd0, match}, 256'd0);
        chk("rst_match_valid", {255'd0, match_valid}, 256'd0);

        // T1: basic point, exp_enc equal to encoding.
        send_point(255'd1, 255'd2, e1, 1'b1, 1'b0);
        stream(e1, 1'b0);

        // T2: reductions of P+1, 2^255-1, and P.
        send_point(P + 255'd1, ALL1, e2a, 1'b1, 1'b0);
        stream(e2a, 1'b0);
        send_point(P, ALL1, e2b, 1'b1, 1'b0);
        stream(e2b, 1'b0);

        // T3: y=P gives all-zero bytes; comparator hit then miss.
        send_point(255'd2, P, 256'd0, 1'b1, 1'b0);
        stream(256'd0, 1'b0);
        send_point(255'd2, P, 256'd1, 1'b0, 1'b0);
        stream(256'd0, 1'b0);

        // T4: out_ready toggling every cycle.
        send_point(255'd1, 255'd2, e1, 1'b1, 1'b0);
        stream(e1, 1'b1);

        // T5: reset in the middle of SEND at byte 10, then a fresh point.
        send_point(255'd0, 255'hAB << 80, e5, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk);
        chk("abort_byte10", {248'd0, bus.out_data}, 256'hAB);
        chk("abort_busy_before", {255'd0, busy}, 256'd1);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("abort_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_pt_ready", {255'd0, bus.pt_ready}, 256'd1);
        chk("abort_out_data", {248'd0, bus.out_data}, 256'd0);
        send_point(255'd1, 255'd2, e1, 1'b1, 1'b0);
        stream(e1, 1'b0);

        // T6: pt_valid held high; a new point each handshake, 2-cycle gap between streams.
        send_point(255'd1, 255'd2, e1, 1'b1, 1'b1);
        bus.px = P + 255'd1;
        bus.py = ALL1;
        stream(e1, 1'b0);
        send_point(P + 255'd1, ALL1, e2a, 1'b1, 1'b1);
        bus.px = 255'd0;
        bus.py = 255'hAB << 80;
        stream(e2a, 1'b0);
        send_point(255'd0, 255'hAB << 80, e5, 1'b1, 1'b0);
        stream(e5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
